// File: rtl/memory_stage_pkg.sv
// Shared types and encodings for the memory stage: word type, NOP, opcodes,
// load/store funct3 codes, FSM states and request-formatting helpers.
package memory_stage_pkg;

   typedef logic [31:0] word_t;

   localparam word_t NOP = 32'h0000_0013;

   typedef enum logic [6:0] {
      OP_LUI    = 7'b0110111,
      OP_AUIPC  = 7'b0010111,
      OP_JAL    = 7'b1101111,
      OP_JALR   = 7'b1100111,
      OP_BRANCH = 7'b1100011,
      OP_LOAD   = 7'b0000011,
      OP_STORE  = 7'b0100011,
      OP_IMM    = 7'b0010011,
      OP_REG    = 7'b0110011
   } opcode_t;

   // Load and store codes share values, so they cannot live in one enum.
   typedef logic [2:0] mem_f3_t;
   localparam mem_f3_t LB  = 3'b000;
   localparam mem_f3_t LH  = 3'b001;
   localparam mem_f3_t LW  = 3'b010;
   localparam mem_f3_t LBU = 3'b100;
   localparam mem_f3_t LHU = 3'b101;
   localparam mem_f3_t SB  = 3'b000;
   localparam mem_f3_t SH  = 3'b001;
   localparam mem_f3_t SW  = 3'b010;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } memstate_t;

   function automatic logic f3_supported(input logic is_store, input mem_f3_t f3);
      logic ok;
      if (is_store)
         ok = (f3 == SB) || (f3 == SH) || (f3 == SW);
      else
         ok = (f3 == LB) || (f3 == LH) || (f3 == LW) || (f3 == LBU) || (f3 == LHU);
      return ok;
   endfunction

   function automatic logic is_misaligned(input mem_f3_t f3, input logic [1:0] a);
      logic mis;
      case (f3[1:0])
         2'b01:   mis = a[0];
         2'b10:   mis = (a != 2'b00);
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

   // Access width lives in funct3[1:0] for both loads and stores.
   function automatic logic [3:0] mem_be(input mem_f3_t f3, input logic [1:0] a);
      logic [3:0] be;
      case (f3[1:0])
         2'b00:   be = 4'b0001 << a;
         2'b01:   be = 4'b0011 << {a[1], 1'b0};
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   function automatic word_t store_wdata(input mem_f3_t f3, input word_t d);
      word_t w;
      case (f3[1:0])
         2'b00:   w = {4{d[7:0]}};
         2'b01:   w = {2{d[15:0]}};
         default: w = d;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory request/response bus between the memory stage (master) and
// the data memory (slave).
interface memory_stage_if;
   import memory_stage_pkg::*;

   logic       dmem_req;
   logic       dmem_we;
   word_t      dmem_addr;
   word_t      dmem_wdata;
   logic [3:0] dmem_be;
   logic       dmem_ack;
   word_t      dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
      input  dmem_ack, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
      output dmem_ack, dmem_rdata
   );

endinterface

// File: rtl/memory_stage_load_format.sv
// Load result formatting: picks the byte/halfword lane from the read word and
// sign- or zero-extends it according to funct3.
module load_format
   import memory_stage_pkg::*;
(
   input  word_t      rdata,
   input  logic [1:0] addr,
   input  mem_f3_t    funct3,
   output word_t      result
);

   word_t       shifted;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   always_comb begin
      shifted = rdata >> {addr, 3'b000};
      lane_b  = shifted[7:0];
      lane_h  = addr[1] ? rdata[31:16] : rdata[15:0];
      case (funct3)
         LB:      result = {{24{lane_b[7]}}, lane_b};
         LH:      result = {{16{lane_h[15]}}, lane_h};
         LW:      result = rdata;
         LBU:     result = {24'h0, lane_b};
         LHU:     result = {16'h0, lane_h};
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/memory_stage.sv
// Pipeline memory stage: passes non-memory instructions through and runs
// load/store transactions on the data-memory bus with timeout and hold support.
module memory_stage
   import memory_stage_pkg::*;
#(
   parameter int unsigned ACK_TIMEOUT = 64
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          stall_m,
   input  word_t         pc_in,
   input  word_t         instr_in,
   input  word_t         data_in,
   input  word_t         store_data_in,
   output word_t         pc_out,
   output word_t         instr_out,
   output word_t         data_out,
   output logic          misalign_out,
   output logic          fault_out,
   output logic          busy_m,
   memory_stage_if.master dmem
);

   localparam int unsigned CW = $clog2(ACK_TIMEOUT + 1);

   memstate_t   state;
   word_t       req_pc;
   word_t       req_instr;
   word_t       req_addr;
   word_t       buf_data;
   logic        buf_fault;
   logic [CW-1:0] tmo_cnt;

   logic        is_load;
   logic        is_store;
   logic        is_mem;
   logic        f3_ok;
   logic        mis;
   logic        start;
   logic        tmo_hit;
   logic        req_is_store;
   word_t       load_res;
   word_t       res_data;
   logic        res_fault;

   load_format u_load_format (
      .rdata  (dmem.dmem_rdata),
      .addr   (req_addr[1:0]),
      .funct3 (req_instr[14:12]),
      .result (load_res)
   );

   always_comb begin
      is_load      = (instr_in[6:0] == OP_LOAD);
      is_store     = (instr_in[6:0] == OP_STORE);
      is_mem       = is_load || is_store;
      f3_ok        = f3_supported(is_store, instr_in[14:12]);
      mis          = is_misaligned(instr_in[14:12], data_in[1:0]);
      start        = (state == IDLE) && is_mem && f3_ok && !mis;
      tmo_hit      = (state == ACCESS) && !dmem.dmem_ack && (tmo_cnt == CW'(ACK_TIMEOUT - 1));
      req_is_store = (req_instr[6:0] == OP_STORE);
      res_fault    = tmo_hit;
      res_data     = tmo_hit ? '0 : (req_is_store ? req_addr : load_res);
      // The timeout cycle also completes the instruction, so upstream must advance.
      busy_m       = start || ((state == ACCESS) && !dmem.dmem_ack && !tmo_hit);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state           <= IDLE;
         dmem.dmem_req   <= 1'b0;
         dmem.dmem_we    <= 1'b0;
         dmem.dmem_be    <= '0;
         dmem.dmem_addr  <= '0;
         dmem.dmem_wdata <= '0;
         pc_out          <= '0;
         instr_out       <= NOP;
         data_out        <= '0;
         misalign_out    <= 1'b0;
         fault_out       <= 1'b0;
         tmo_cnt         <= '0;
         req_pc          <= '0;
         req_instr       <= NOP;
         req_addr        <= '0;
         buf_data        <= '0;
         buf_fault       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  dmem.dmem_req   <= 1'b1;
                  dmem.dmem_we    <= is_store;
                  dmem.dmem_addr  <= {data_in[31:2], 2'b00};
                  dmem.dmem_be    <= mem_be(instr_in[14:12], data_in[1:0]);
                  dmem.dmem_wdata <= store_wdata(instr_in[14:12], store_data_in);
                  req_pc          <= pc_in;
                  req_instr       <= instr_in;
                  req_addr        <= data_in;
                  tmo_cnt         <= '0;
                  state           <= ACCESS;
               end else if (!stall_m) begin
                  pc_out       <= pc_in;
                  instr_out    <= instr_in;
                  data_out     <= (is_mem && !f3_ok) ? '0 : data_in;
                  misalign_out <= is_mem && f3_ok && mis;
                  fault_out    <= is_mem && !f3_ok;
               end
            end
            ACCESS: begin
               if (dmem.dmem_ack || tmo_hit) begin
                  dmem.dmem_req <= 1'b0;
                  dmem.dmem_we  <= 1'b0;
                  if (!stall_m) begin
                     pc_out       <= req_pc;
                     instr_out    <= req_instr;
                     data_out     <= res_data;
                     misalign_out <= 1'b0;
                     fault_out    <= res_fault;
                     state        <= IDLE;
                  end else begin
                     buf_data  <= res_data;
                     buf_fault <= res_fault;
                     state     <= DONE;
                  end
               end else begin
                  tmo_cnt <= tmo_cnt + CW'(1);
               end
            end
            DONE: begin
               if (!stall_m) begin
                  pc_out       <= req_pc;
                  instr_out    <= req_instr;
                  data_out     <= buf_data;
                  misalign_out <= 1'b0;
                  fault_out    <= buf_fault;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_memory_stage.sv
// Directed scoreboard bench for memory_stage: expected writeback results are
// queued as instructions are driven and checked when they reach the outputs.
module tb_memory_stage;
   import memory_stage_pkg::*;

   typedef struct {
      word_t pc;
      word_t instr;
      word_t data;
      logic  mis;
      logic  fault;
   } exp_t;

   logic  clk;
   logic  rst;
   logic  stall_m;
   word_t pc_in, instr_in, data_in, store_data_in;
   word_t pc_out, instr_out, data_out;
   logic  misalign_out, fault_out, busy_m;

   memory_stage_if dmem_bus ();

   memory_stage #(.ACK_TIMEOUT(64)) dut (
      .clk           (clk),
      .rst           (rst),
      .stall_m       (stall_m),
      .pc_in         (pc_in),
      .instr_in      (instr_in),
      .data_in       (data_in),
      .store_data_in (store_data_in),
      .pc_out        (pc_out),
      .instr_out     (instr_out),
      .data_out      (data_out),
      .misalign_out  (misalign_out),
      .fault_out     (fault_out),
      .busy_m        (busy_m),
      .dmem          (dmem_bus)
   );

   int   total = 0;
   int   bad   = 0;
   exp_t sb[$];
   exp_t last_exp;

   logic       req_seen_s;
   logic       req_we_s;
   word_t      req_addr_s;
   logic [3:0] req_be_s;
   word_t      req_wdata_s;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish (observed=timeout required=finish)");
      $fatal(1, "watchdog expired");
   end

   function automatic word_t mk(input logic [6:0] op, input logic [2:0] f3);
      return {12'h000, 5'd1, f3, 5'd2, op};
   endfunction

   function automatic logic [127:0] pk(input exp_t e);
      return {30'b0, e.pc, e.instr, e.data, e.mis, e.fault};
   endfunction

   function automatic logic [127:0] outs_now();
      return {30'b0, pc_out, instr_out, data_out, misalign_out, fault_out};
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] req);
      total++;
      assert (obs === req) else begin
         bad++;
         $error("FAIL %s observed=%0h required=%0h", tag, obs, req);
      end
   endtask

   task automatic push(input word_t pc, input word_t instr, input word_t data,
                       input logic mis, input logic fault);
      exp_t e;
      e.pc = pc; e.instr = instr; e.data = data; e.mis = mis; e.fault = fault;
      sb.push_back(e);
   endtask

   task automatic check_out(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 128'(sb.size()), 128'd1);
      end else begin
         e = sb.pop_front();
         chk(tag, outs_now(), pk(e));
         last_exp = e;
      end
   endtask

   task automatic check_reset(input string tag);
      chk(tag,
          {24'b0, pc_out, instr_out, data_out, misalign_out, fault_out,
           dmem_bus.dmem_req, dmem_bus.dmem_we, dmem_bus.dmem_be},
          {24'b0, 32'h0, NOP, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One memory transaction: ack after ack_wait ACCESS cycles, stall_m held
   // for `hold` cycles starting with the ack cycle.
   task automatic do_access(input word_t pc, input word_t instr, input word_t addr,
                            input word_t sd, input int unsigned ack_wait,
                            input word_t rdata, input int unsigned hold,
                            output int unsigned busy_n);
      int unsigned stable_err;
      stable_err = 0;
      busy_n = 0;
      pc_in = pc; instr_in = instr; data_in = addr; store_data_in = sd; stall_m = 1'b0;
      #1;
      if (busy_m) busy_n++;
      tick();
      req_seen_s  = dmem_bus.dmem_req;
      req_we_s    = dmem_bus.dmem_we;
      req_addr_s  = dmem_bus.dmem_addr;
      req_be_s    = dmem_bus.dmem_be;
      req_wdata_s = dmem_bus.dmem_wdata;
      for (int unsigned i = 0; i < ack_wait; i++) begin
         if (busy_m) busy_n++;
         if (dmem_bus.dmem_req !== 1'b1 || dmem_bus.dmem_addr !== req_addr_s ||
             dmem_bus.dmem_be !== req_be_s || dmem_bus.dmem_we !== req_we_s ||
             dmem_bus.dmem_wdata !== req_wdata_s)
            stable_err++;
         tick();
      end
      chk("req_stable", 128'(stable_err), 128'd0);
      dmem_bus.dmem_ack   = 1'b1;
      dmem_bus.dmem_rdata = rdata;
      stall_m = (hold > 0);
      #1;
      if (busy_m) busy_n++;
      tick();
      dmem_bus.dmem_ack   = 1'b0;
      dmem_bus.dmem_rdata = 32'hA5A5_5A5A;
      chk("req_cleared", 128'(dmem_bus.dmem_req), 128'd0);
      if (hold > 0) begin
         pc_in = 32'h0000_7770; instr_in = 32'h00A00093; data_in = 32'h0000_00AA;
         for (int unsigned i = 1; i < hold; i++) begin
            chk("done_hold_outs", outs_now(), pk(last_exp));
            chk("done_busy", 128'(busy_m), 128'd0);
            tick();
         end
         chk("done_hold_outs_last", outs_now(), pk(last_exp));
         stall_m = 1'b0;
         tick();
      end
      pc_in = '0; instr_in = NOP; data_in = '0; store_data_in = '0;
   endtask

   initial begin
      int unsigned bn;
      int unsigned n;
      word_t sw_i, sh_i, lb_i, lbu_i, lh_i, lhu_i, lw_i, bad_i;

      sw_i  = mk(OP_STORE, SW);
      sh_i  = mk(OP_STORE, SH);
      lb_i  = mk(OP_LOAD, LB);
      lbu_i = mk(OP_LOAD, LBU);
      lh_i  = mk(OP_LOAD, LH);
      lhu_i = mk(OP_LOAD, LHU);
      lw_i  = mk(OP_LOAD, LW);
      bad_i = mk(OP_LOAD, 3'b011);

      last_exp.pc = '0; last_exp.instr = NOP; last_exp.data = '0;
      last_exp.mis = 1'b0; last_exp.fault = 1'b0;

      rst = 1'b1; stall_m = 1'b0;
      pc_in = '0; instr_in = NOP; data_in = '0; store_data_in = '0;
      dmem_bus.dmem_ack = 1'b0; dmem_bus.dmem_rdata = '0;
      #3 rst = 1'b0;
      #20;
      check_reset("reset_values");
      @(negedge clk) rst = 1'b1;
      tick();

      // Pass-through of an ALU instruction.
      pc_in = 32'h1000; instr_in = 32'h00500093; data_in = 32'h5;
      push(32'h1000, 32'h00500093, 32'h5, 1'b0, 1'b0);
      #1 chk("addi_busy", 128'(busy_m), 128'd0);
      tick();
      check_out("addi_pass");

      // Downstream stall holds outputs.
      pc_in = 32'h1004; instr_in = 32'h002081B3; data_in = 32'h77; stall_m = 1'b1;
      tick();
      chk("stall_hold", outs_now(), pk(last_exp));
      stall_m = 1'b0;
      push(32'h1004, 32'h002081B3, 32'h77, 1'b0, 1'b0);
      tick();
      check_out("stall_release");

      // SW, ack after 3 ACCESS cycles.
      push(32'h2000, sw_i, 32'h100, 1'b0, 1'b0);
      do_access(32'h2000, sw_i, 32'h100, 32'h12345678, 3, 32'h0, 0, bn);
      chk("sw_req", {req_seen_s, req_we_s, req_addr_s, req_be_s, req_wdata_s},
          {1'b1, 1'b1, 32'h100, 4'b1111, 32'h12345678});
      chk("sw_busy_cycles", 128'(bn), 128'd4);
      check_out("sw_result");

      // LB / LBU from the top byte lane.
      push(32'h2004, lb_i, 32'hFFFFFF80, 1'b0, 1'b0);
      do_access(32'h2004, lb_i, 32'h203, 32'h0, 1, 32'h80FFFFFF, 0, bn);
      chk("lb_req", {req_seen_s, req_we_s, req_addr_s, req_be_s},
          {1'b1, 1'b0, 32'h200, 4'b1000});
      check_out("lb_result");

      push(32'h2008, lbu_i, 32'h00000080, 1'b0, 1'b0);
      do_access(32'h2008, lbu_i, 32'h203, 32'h0, 0, 32'h80FFFFFF, 0, bn);
      check_out("lbu_result");

      // SH to the upper halfword.
      push(32'h200C, sh_i, 32'h102, 1'b0, 1'b0);
      do_access(32'h200C, sh_i, 32'h102, 32'h0000BEEF, 0, 32'h0, 0, bn);
      chk("sh_req", {req_seen_s, req_we_s, req_addr_s, req_be_s, req_wdata_s},
          {1'b1, 1'b1, 32'h100, 4'b1100, 32'hBEEFBEEF});
      check_out("sh_result");

      // Misaligned LW: no request, pass-through with misalign flag.
      pc_in = 32'h2010; instr_in = lw_i; data_in = 32'h102;
      push(32'h2010, lw_i, 32'h102, 1'b1, 1'b0);
      #1 chk("lw_mis_busy", 128'(busy_m), 128'd0);
      tick();
      chk("lw_mis_noreq", 128'(dmem_bus.dmem_req), 128'd0);
      check_out("lw_misaligned");

      // Halfword and word loads.
      push(32'h2014, lh_i, 32'hFFFF8001, 1'b0, 1'b0);
      do_access(32'h2014, lh_i, 32'h202, 32'h0, 2, 32'h80011234, 0, bn);
      check_out("lh_result");
      push(32'h2018, lhu_i, 32'h0000F234, 1'b0, 1'b0);
      do_access(32'h2018, lhu_i, 32'h200, 32'h0, 0, 32'h8001F234, 0, bn);
      check_out("lhu_result");
      push(32'h201C, lw_i, 32'hCAFEF00D, 1'b0, 1'b0);
      do_access(32'h201C, lw_i, 32'h204, 32'h0, 1, 32'hCAFEF00D, 0, bn);
      chk("lw_req", {req_seen_s, req_we_s, req_addr_s, req_be_s},
          {1'b1, 1'b0, 32'h204, 4'b1111});
      check_out("lw_result");

      // Ack arrives while stall_m is high: result buffered in DONE.
      push(32'h3000, lw_i, 32'hDEADBEEF, 1'b0, 1'b0);
      do_access(32'h3000, lw_i, 32'h300, 32'h0, 1, 32'hDEADBEEF, 2, bn);
      check_out("done_release");

      // Stray ack in IDLE is ignored.
      pc_in = 32'h3004; instr_in = NOP; data_in = '0;
      dmem_bus.dmem_ack = 1'b1; dmem_bus.dmem_rdata = 32'h1111_2222;
      push(32'h3004, NOP, 32'h0, 1'b0, 1'b0);
      tick();
      dmem_bus.dmem_ack = 1'b0;
      chk("idle_ack_noreq", 128'(dmem_bus.dmem_req), 128'd0);
      check_out("idle_ack_pass");

      // Unsupported load funct3 reports a fault without a request.
      pc_in = 32'h3008; instr_in = bad_i; data_in = 32'h208;
      push(32'h3008, bad_i, 32'h0, 1'b0, 1'b1);
      #1 chk("badf3_busy", 128'(busy_m), 128'd0);
      tick();
      chk("badf3_noreq", 128'(dmem_bus.dmem_req), 128'd0);
      check_out("badf3_fault");

      // No ack: abandoned after 64 ACCESS cycles.
      pc_in = 32'h4000; instr_in = lw_i; data_in = 32'h400;
      push(32'h4000, lw_i, 32'h0, 1'b0, 1'b1);
      tick();
      chk("tmo_req_up", 128'(dmem_bus.dmem_req), 128'd1);
      n = 0;
      while (dmem_bus.dmem_req === 1'b1 && n < 200) begin
         tick();
         n++;
      end
      chk("tmo_cycles", 128'(n), 128'd64);
      check_out("tmo_fault");
      pc_in = 32'h4004; instr_in = NOP; data_in = 32'h0;
      push(32'h4004, NOP, 32'h0, 1'b0, 1'b0);
      tick();
      check_out("tmo_back_idle");

      // Reset in the middle of ACCESS.
      pc_in = 32'h5000; instr_in = lw_i; data_in = 32'h500;
      tick();
      tick();
      chk("rst_mid_req_up", 128'(dmem_bus.dmem_req), 128'd1);
      #2 rst = 1'b0;
      #1 check_reset("rst_mid_access");
      pc_in = 32'h5004; instr_in = 32'h00300093; data_in = 32'h3;
      @(negedge clk) rst = 1'b1;
      push(32'h5004, 32'h00300093, 32'h3, 1'b0, 1'b0);
      tick();
      check_out("post_reset_pass");

      chk("sb_drained", 128'(sb.size()), 128'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameter: ACK_TIMEOUT, default 64, maximum cycles in ACCESS without dmem_ack before the access is abandoned as a fault.
REQ-002 clk  in  1  single clock; all state on posedge clk.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 stall_m  in  1  downstream hold; output registers keep their value while high.
REQ-005 pc_in, instr_in  in  32 each  from Execute; bubbles arrive as NOP.
REQ-006 data_in  in  32  ALU result; this is the effective address for loads and stores.
REQ-007 store_data_in  in  32  rs2 value for stores.
REQ-008 pc_out, instr_out, data_out  out  32 each  registered results to writeback.
REQ-009 misalign_out, fault_out  out  1 each  registered exception flags travelling with instr_out.
REQ-010 busy_m  out  1  combinational stall request to upstream stages.
REQ-011 dmem_req, dmem_we  out  1 each  registered memory request and write strobe.
REQ-012 dmem_addr, dmem_wdata  out  32 each  word-aligned address and replicated store data.
REQ-013 dmem_be  out  4  byte enables.
REQ-014 dmem_ack  in  1  completion; dmem_rdata  in  32  read word, valid when dmem_ack is high.

Function
REQ-015 Non-memory instruction or NOP with stall_m low: capture pc_in, instr_in and data_in into the outputs at the next edge, with 1-cycle latency and both flags 0.
REQ-016 FSM states: IDLE, ACCESS, DONE.
REQ-017 IDLE, aligned OP_LOAD or OP_STORE: busy_m high that cycle; dmem_req, dmem_we, dmem_addr, dmem_be and dmem_wdata are registered; next state ACCESS.
REQ-018 Alignment rule: halfword needs addr[0]=0; word needs addr[1:0]=0; byte accesses are always aligned.
REQ-019 Misaligned access: no request is issued; behave as pass-through with misalign_out=1 and data_out = address.
REQ-020 ACCESS: dmem_req and all request fields are held stable until dmem_ack; busy_m = !dmem_ack.
REQ-021 dmem_ack with stall_m low: clear dmem_req and load the outputs (load: formatted rdata; store: address); next state IDLE.
REQ-022 dmem_ack with stall_m high: clear dmem_req and buffer the formatted result; next state DONE.
REQ-023 DONE: busy_m stays 0 while stall_m is high and the upstream input is ignored; when stall_m falls, load the buffered result; next state IDLE.
REQ-024 Timeout counter runs in ACCESS and is cleared on entry. When it reaches ACCESS_TIMEOUT... (i.e. ACK_TIMEOUT): dmem_req drops, result written with fault_out=1 and data_out=0, next state IDLE.
REQ-025 dmem_addr = {addr[31:2], 2'b00}.
REQ-026 Byte enables: SB gives 0001<<addr[1:0]; SH gives 0011<<{addr[1],1'b0}; SW gives 1111.
REQ-027 Store data: SB replicates byte 4×; SH replicates halfword 2×; SW passes the word unchanged.
REQ-028 Load formatting selects the lane by addr[1:0]: LB and LH sign-extend, LBU and LHU zero-extend, LW passes the word; unsupported funct3 is treated as a fault.
REQ-029 A dmem_ack arriving in IDLE or DONE is ignored.

Reset
REQ-030 rst low asynchronously forces: state IDLE, dmem_req=0, dmem_we=0, dmem_be=0, pc_out=0, instr_out=NOP (0x00000013), data_out=0, both flags 0, timeout counter 0.
REQ-031 Reset during ACCESS abandons the access; the memory side must tolerate dmem_req dropping without ack.

Structure
REQ-032 defs.sv holds word_t, NOP, opcode_t, the new mem_f3_t (LB/LH/LW/LBU/LHU/SB/SH/SW) and memstate_t; no local copies of these are allowed.
REQ-033 Load lane selection and extension live in one combinational sub-module, load_format, with inputs rdata, addr[1:0] and funct3, and output word_t.

Verification
REQ-034 SW x=0x12345678 @0x100, ack after 3 cycles: be=1111, addr=0x100, busy_m high 4 cycles, data_out=0x100.
REQ-035 LB @0x203 with rdata=0x80FFFFFF: data_out=0xFFFFFF80. LBU @0x203 with the same rdata: data_out=0x00000080.
REQ-036 SH @0x102, data 0xBEEF: be=1100, wdata=0xBEEFBEEF. LW @0x102: no dmem_req, misalign_out=1.
REQ-037 ack with stall_m high for 2 cycles: outputs unchanged in DONE; result appears on the edge after stall_m falls.
REQ-038 No ack for 64 cycles: fault_out=1, dmem_req=0, state IDLE. Assert rst mid-ACCESS: all outputs at reset values immediately.
